// File: rtl/z_word_packer.sv
// Packs accepted serial z bits LSB-first into W-bit words with length and ones-count side fields.
// Latency: a word appears on out_* one cycle after its last bit (or its flush) is accepted.
// Backpressure: the single output slot is drainable the same cycle; input stalls only on the word-completing bit.
module z_word_packer #(
  parameter int W  = 8,
  parameter int LW = $clog2(W+1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          z,
  input  logic          flush,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_data,
  output logic [LW-1:0] out_len,
  output logic [LW-1:0] out_ones,
  output logic          flush_err
);

  // IDLE means no bits are held (cnt==0); FILL means a partial word is held.
  typedef enum logic {
    S_IDLE = 1'b0,
    S_FILL = 1'b1
  } state_e;

  state_e         state_q, state_d;
  logic [W-1:0]   sr_q, sr_d;
  logic [LW-1:0]  cnt_q, cnt_d;
  logic [LW-1:0]  ones_q, ones_d;

  logic           out_valid_q;
  logic [W-1:0]   out_data_q;
  logic [LW-1:0]  out_len_q;
  logic [LW-1:0]  out_ones_q;
  logic           flush_err_q;

  logic           slot_free;
  logic           last_slot;
  logic           in_ready_c;
  logic           accept;
  logic           word_done;
  logic           pending;
  logic           flush_go;
  logic           flush_blk;
  logic           emit;

  // Word as it would look including this cycle's accepted bit (if any).
  logic [W-1:0]   word_data;
  logic [LW-1:0]  word_len;
  logic [LW-1:0]  word_ones;

  // Handshake and flush decode. A draining output slot counts as free this cycle.
  always_comb begin
    slot_free  = !out_valid_q || out_ready;
    last_slot  = (cnt_q == LW'(W - 1));
    in_ready_c = !(last_slot && !slot_free);
    accept     = in_valid && in_ready_c;
    word_done  = accept && last_slot;
    pending    = (state_q == S_FILL) || accept;
    // A flush coinciding with a completing bit is absorbed by the full word.
    flush_go   = flush && slot_free && pending && !word_done;
    flush_blk  = flush && !slot_free && pending;
    emit       = word_done || flush_go;
  end

  // Merge the accepted bit into the shift register at position cnt.
  always_comb begin
    word_data = sr_q;
    for (int i = 0; i < W; i++) begin
      if (accept && (cnt_q == LW'(i))) begin
        word_data[i] = z;
      end
    end
    word_len  = cnt_q + LW'(accept);
    word_ones = ones_q + LW'(accept && z);
  end

  // Next state of the fill side: everything clears when a word leaves.
  always_comb begin
    sr_d    = emit ? '0 : word_data;
    cnt_d   = emit ? '0 : word_len;
    ones_d  = emit ? '0 : word_ones;
    state_d = (cnt_d != '0) ? S_FILL : S_IDLE;
  end

  // Fill-side state: shift register, bit counter, running ones count, FSM.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      ones_q  <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      ones_q  <= ones_d;
    end
  end

  // One-deep output register; held stable while stalled, cleared valid on drain.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_len_q   <= '0;
      out_ones_q  <= '0;
    end else if (emit) begin
      out_valid_q <= 1'b1;
      out_data_q  <= word_data;
      out_len_q   <= word_len;
      out_ones_q  <= word_ones;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  // Sticky flag for a flush that could not be honoured because the slot was busy.
  always_ff @(posedge clk) begin
    if (reset) begin
      flush_err_q <= 1'b0;
    end else if (flush_blk) begin
      flush_err_q <= 1'b1;
    end
  end

  assign in_ready  = in_ready_c;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_len   = out_len_q;
  assign out_ones  = out_ones_q;
  assign flush_err = flush_err_q;

endmodule

// File: tb/tb_z_word_packer.sv
// Bench for z_word_packer (W=8): table of word vectors plus hand sequences for stall, flush error and reset.
module tb_z_word_packer;

  localparam int W  = 8;
  localparam int LW = $clog2(W+1);

  logic          clk;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic          z;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic [LW-1:0] out_len;
  logic [LW-1:0] out_ones;
  logic          flush_err;

  z_word_packer #(.W(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .z         (z),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_len   (out_len),
    .out_ones  (out_ones),
    .flush_err (flush_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [7:0] d;
    int         len;
    int         ones;
  } exp_t;

  // mode 0: no flush, 1: flush with the last bit, 2: flush in the cycle after the last bit
  typedef struct {
    int          nbits;
    logic [31:0] bits;
    int          mode;
    logic [7:0]  exp_d;
    int          exp_len;
    int          exp_ones;
  } vec_t;

  exp_t sb[$];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  task automatic push_exp(input logic [7:0] d, input int len, input int ones);
    exp_t e;
    e.d = d; e.len = len; e.ones = ones;
    sb.push_back(e);
  endtask

  // Scoreboard: compare every word the consumer takes against the oldest expectation.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_word: got data=0x%0h len=%0d, no word expected", out_data, out_len);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("word_data", int'(out_data), int'(e.d));
        check("word_len",  int'(out_len),  e.len);
        check("word_ones", int'(out_ones), e.ones);
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the bit has been accepted.
  task automatic send_bit(input logic b, input logic fl);
    logic ok;
    int   guard;
    in_valid = 1'b1;
    z        = b;
    flush    = fl;
    ok       = 1'b0;
    guard    = 0;
    while (!ok && guard < 50) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      guard++;
    end
    if (!ok) begin
      n_total++;
      $display("FAIL accept_timeout: got in_ready=0 for 50 cycles, required an accept");
    end
    in_valid = 1'b0;
    flush    = 1'b0;
    z        = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] v);
    for (int k = 0; k < 8; k++) send_bit(v[k], 1'b0);
  endtask

  task automatic flush_pulse();
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  vec_t vecs[8];

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    z         = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;

    vecs[0] = '{8, 32'h8D, 0, 8'h8D, 8, 4};
    vecs[1] = '{3, 32'h03, 2, 8'h03, 3, 2};
    vecs[2] = '{5, 32'h19, 1, 8'h19, 5, 3};
    vecs[3] = '{8, 32'h00, 0, 8'h00, 8, 0};
    vecs[4] = '{8, 32'hFF, 1, 8'hFF, 8, 8};
    vecs[5] = '{1, 32'h01, 2, 8'h01, 1, 1};
    vecs[6] = '{7, 32'h55, 2, 8'h55, 7, 4};
    vecs[7] = '{8, 32'hA5, 0, 8'hA5, 8, 4};

    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_data",  int'(out_data),  0);
    check("rst_out_len",   int'(out_len),   0);
    check("rst_out_ones",  int'(out_ones),  0);
    check("rst_flush_err", int'(flush_err), 0);
    check("rst_in_ready",  int'(in_ready),  1);
    @(posedge clk);
    #1;

    // Table of words with free-running consumer.
    for (int v = 0; v < 8; v++) begin
      push_exp(vecs[v].exp_d, vecs[v].exp_len, vecs[v].exp_ones);
      for (int k = 0; k < vecs[v].nbits; k++) begin
        send_bit(vecs[v].bits[k], (vecs[v].mode == 1) && (k == vecs[v].nbits - 1));
      end
      if (vecs[v].mode == 2) flush_pulse();
      idle(3);
      check($sformatf("drain_vec%0d", v), sb.size(), 0);
    end

    // Flush with nothing held: no word, no error.
    flush_pulse();
    idle(3);
    check("empty_flush_valid", int'(out_valid), 0);
    check("empty_flush_err",   int'(flush_err), 0);

    // Backpressure: two all-ones words with the consumer stalled.
    out_ready = 1'b0;
    push_exp(8'hFF, 8, 8);
    push_exp(8'hFF, 8, 8);
    begin
      int acc;
      int guard;
      acc = 0;
      guard = 0;
      in_valid = 1'b1;
      z = 1'b1;
      while (acc < 15 && guard < 100) begin
        @(negedge clk);
        if (in_ready) acc++;
        @(posedge clk);
        #1;
        guard++;
      end
      check("stall_accepted_bits", acc, 15);
    end
    @(negedge clk);
    check("stall_in_ready_low", int'(in_ready),  0);
    check("stall_out_valid",    int'(out_valid), 1);
    check("stall_out_data",     int'(out_data),  8'hFF);
    check("stall_out_len",      int'(out_len),   8);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("stall_hold_data",    int'(out_data),  8'hFF);
    check("stall_hold_in_rdy",  int'(in_ready),  0);
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(negedge clk);
    check("drain_in_ready",     int'(in_ready),  1);
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    z         = 1'b0;
    @(negedge clk);
    check("second_out_valid",   int'(out_valid), 1);
    check("second_out_data",    int'(out_data),  8'hFF);
    check("second_queue_left",  sb.size(), 1);
    @(posedge clk);
    #1 out_ready = 1'b1;
    idle(3);
    check("stall_drain_all", sb.size(), 0);

    // Blocked flush: stalled slot with two bits pending.
    out_ready = 1'b0;
    push_exp(8'h0F, 8, 4);
    send_word(8'h0F);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    flush_pulse();
    @(negedge clk);
    check("blk_flush_err",  int'(flush_err), 1);
    check("blk_out_data",   int'(out_data),  8'h0F);
    check("blk_out_len",    int'(out_len),   8);
    @(posedge clk);
    #1 out_ready = 1'b1;
    push_exp(8'hFD, 8, 7);
    for (int k = 0; k < 6; k++) send_bit(1'b1, 1'b0);
    idle(3);
    check("blk_err_sticky", int'(flush_err), 1);
    check("blk_drain_all",  sb.size(), 0);

    // Reset mid-word with a stalled output word.
    out_ready = 1'b0;
    send_word(8'h81);
    for (int k = 0; k < 5; k++) send_bit(1'b1, 1'b0);
    @(negedge clk);
    check("pre_rst_out_valid", int'(out_valid), 1);
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("mid_rst_out_valid", int'(out_valid), 0);
    check("mid_rst_out_data",  int'(out_data),  0);
    check("mid_rst_out_len",   int'(out_len),   0);
    check("mid_rst_out_ones",  int'(out_ones),  0);
    check("mid_rst_flush_err", int'(flush_err), 0);
    check("mid_rst_in_ready",  int'(in_ready),  1);
    @(posedge clk);
    #1 out_ready = 1'b1;
    push_exp(8'h3C, 8, 4);
    send_word(8'h3C);
    idle(3);
    check("post_rst_drain", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Absolute time limit so the bench always ends.
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at 200000, required completion");
    $display("%0d/%0d checks passed", n_pass, n_total + 1);
    $fatal(1);
  end

endmodule
